pp_hop_parser: RTL
==================

# pp_hop_parser

Path-parser hop stage: buffers the hop-info words produced by the path-parser read control, then walks them in order. It selects the hop whose index equals the program counter carried in the anchor entry and hands that hop to the downstream forwarding logic through a valid/ready handshake. It then pulses `parser_done`, which tells the read control to abort its walk and reset this block's FIFO.

## Interface
- `DEPTH`, 8 — hop FIFO entries; power of two, at least 4.
- `ADDR_NBITS`, 3 — log2(`DEPTH`).
- `clk`  in  1  — single clock.
- `` `RESET_SIG ``  in  1  — reset; synchronous, active-high.
- `hop_fifo_reset`  in  1  — clears FIFO and FSM (abort).
- `hop_fifo_wr`  in  1  — push strobe.
- `hop_fifo_wdata`  in  48  — `` `HOP_INFO_RANGE `` word:
  - [47:32] hop pointer
  - [31:24] byte0: [31:29] hop type, [28] instruction flag
  - [23:16] byte1
  - [15:8] byte2 or pc
  - [7:0] flags
- `hop_fifo_eop`  in  1  — last hop of packet; qualified by `hop_fifo_wr`.
- `hop_fifo_full`  out  1  — count == `DEPTH`.
- `hop_fifo_fullm1`  out  1  — count ≥ `DEPTH`-1.
- `parser_done`  out  1  — one-cycle completion pulse.
- `hop_valid`  out  1  — selected-hop result valid.
- `hop_ready`  in  1  — downstream accepts result.
- `hop_ptr`  out  16  — pointer of the selected hop.
- `hop_type`  out  3  — hop type of the selected hop.
- `hop_is_ins`  out  1  — instruction flag of the selected hop.
- `hop_bytes`  out  24  — bits [31:8] of the selected hop.
- `hop_pc`  out  8  — program counter latched from the anchor.
- `hop_flags`  out  8  — flags latched from the anchor.
- `hop_err`  out  1  — eop reached before the selected hop; qualified by `hop_valid`.

## Operation
- FIFO storage: `DEPTH` × 49 bits (wdata + eop).
  - Write and read pointers are `ADDR_NBITS` wide and wrap naturally.
  - Count is `ADDR_NBITS`+1 bits.
  - Head is read combinationally (show-ahead).
- Write rules:
  - A push while `hop_fifo_full` is dropped; count and contents are unchanged.
  - A push and a pop in the same cycle leave count unchanged.
  - A push into an empty FIFO is not bypassed; the head becomes visible the next cycle.
- FSM states: IDLE, WALK, OUT, DONE, WAIT_RST.
- IDLE, FIFO non-empty:
  - Pop the anchor; latch pc = [15:8] and flags = [7:0]; clear `hop_idx` (8 bits); go to WALK.
  - If the anchor carries eop: set err, go to OUT.
- WALK, FIFO non-empty: pop one entry.
  - `hop_idx` == pc: latch the entry into the result registers with err=0; go to OUT.
  - Otherwise, entry eop: latch the entry with err=1; go to OUT.
  - Otherwise: `hop_idx` += 1. It saturates at 255; a saturated index never matches.
- WALK, FIFO empty: hold.
- OUT:
  - `hop_valid`=1; result outputs are held stable until `hop_valid & hop_ready`, then go to DONE.
  - Entries arriving meanwhile are buffered, not popped.
- DONE: `parser_done`=1 for exactly one cycle; go to WAIT_RST.
- WAIT_RST:
  - No pops; later pushes are buffered; `parser_done`=0.
  - Remain here until `hop_fifo_reset`.
- `hop_fifo_reset`, in any state, has priority over every other event:
  - Pointers and count are zeroed; FSM goes to IDLE; `hop_valid` drops next cycle.
  - A push in the same cycle is discarded.
- Reset values: `hop_fifo_full`, `hop_fifo_fullm1`, `parser_done`, `hop_valid`, `hop_err` = 0; `hop_ptr`, `hop_type`, `hop_is_ins`, `hop_bytes`, `hop_pc`, `hop_flags` = 0; FSM = IDLE; FIFO empty.

## Timing
- `hop_fifo_full` and `hop_fifo_fullm1` are registered from count and reflect pushes and pops of the previous cycle.
  - The writer may push while fullm1 is high only if it did not push the previous cycle.
- Latency, push to consumed:
  - Push at cycle N; head visible at N+1; popped at N+1 when the FSM is in IDLE or WALK.
  - If that entry is selected, `hop_valid` is high at N+2.
- Minimum turnaround: anchor pushed at N, hop 0 pushed at N+1, pc=0:
  - `hop_valid` at N+3.
  - With `hop_ready` tied high, `parser_done` at N+4.
- One pop per cycle maximum, so WALK sustains one hop per cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- pc=2:
  - Stimulus: anchor {ptr=`INITIAL_HOP`, pc=8'h02, flags=8'h5A}, then hops with ptr 4, 6, 9, 11 (eop on 11); `hop_ready`=1.
  - Required: `hop_valid` with `hop_ptr`=9, `hop_err`=0, `hop_pc`=2, `hop_flags`=8'h5A; `parser_done` pulses exactly one cycle later.
- pc=5 with only 3 hops, eop on the 3rd:
  - Required: `hop_valid` with `hop_err`=1, `hop_ptr` = the 3rd hop's pointer.
- Fill all 8 entries with `hop_ready`=0 and the FSM holding in OUT:
  - Required: `hop_fifo_fullm1` after 7 pushes, `hop_fifo_full` after 8; a 9th push is dropped (count stays 8).
  - After `hop_fifo_reset`: full=0, count 0.
- Backpressure: hold `hop_ready`=0 for 10 cycles in OUT.
  - Required: all result outputs stable, no `parser_done`; done one cycle after `hop_ready` rises.
- Abort: assert `hop_fifo_reset` mid-WALK simultaneously with a push.
  - Required: FSM in IDLE, FIFO empty, pushed entry discarded.
  - A following packet parses correctly.
- Assert `` `RESET_SIG `` in OUT.
  - Required: all outputs 0 the next cycle; behaviour identical to power-up.

Source files
------------

// File: rtl/pp_hop_parser_if.sv
// pp_hop_parser_if: write-side and result-side signals of the path-parser hop stage.
//   master : read control / forwarding side (drives pushes, abort, hop_ready)
//   slave  : the hop parser (drives FIFO flags, done pulse and selected-hop result)
interface pp_hop_parser_if;
    logic        hop_fifo_reset;   // abort: clear FIFO and FSM
    logic        hop_fifo_wr;      // push strobe
    logic [47:0] hop_fifo_wdata;   // hop-info word
    logic        hop_fifo_eop;     // last hop of packet, qualified by hop_fifo_wr
    logic        hop_fifo_full;    // count == DEPTH
    logic        hop_fifo_fullm1;  // count >= DEPTH-1
    logic        parser_done;      // one-cycle completion pulse
    logic        hop_valid;        // selected-hop result valid
    logic        hop_ready;        // downstream accepts result
    logic [15:0] hop_ptr;
    logic [2:0]  hop_type;
    logic        hop_is_ins;
    logic [23:0] hop_bytes;
    logic [7:0]  hop_pc;
    logic [7:0]  hop_flags;
    logic        hop_err;          // eop reached before the selected hop

    modport master (
        output hop_fifo_reset, hop_fifo_wr, hop_fifo_wdata, hop_fifo_eop, hop_ready,
        input  hop_fifo_full, hop_fifo_fullm1, parser_done, hop_valid,
               hop_ptr, hop_type, hop_is_ins, hop_bytes, hop_pc, hop_flags, hop_err
    );

    modport slave (
        input  hop_fifo_reset, hop_fifo_wr, hop_fifo_wdata, hop_fifo_eop, hop_ready,
        output hop_fifo_full, hop_fifo_fullm1, parser_done, hop_valid,
               hop_ptr, hop_type, hop_is_ins, hop_bytes, hop_pc, hop_flags, hop_err
    );
endinterface

// File: rtl/pp_hop_parser.sv
// pp_hop_parser: buffers hop-info words in a show-ahead FIFO, pops the anchor
// (carrying pc/flags), walks the hops in order and presents the hop whose index
// equals pc on a valid/ready result port, then pulses parser_done and waits for
// hop_fifo_reset from the read control.
// Ports:
//   clk  - single clock
//   rst  - synchronous active-high reset
//   bus  - pp_hop_parser_if.slave (FIFO write side, flags, result handshake)
module pp_hop_parser #(
    parameter int DEPTH      = 8,
    parameter int ADDR_NBITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    pp_hop_parser_if.slave    bus
);

    localparam logic [ADDR_NBITS:0] FULL_CNT   = (ADDR_NBITS+1)'(DEPTH);
    localparam logic [ADDR_NBITS:0] FULLM1_CNT = (ADDR_NBITS+1)'(DEPTH-1);

    typedef enum logic [2:0] {IDLE, WALK, OUT, DONE, WAIT_RST} state_t;
    state_t state, state_nxt;

    // FIFO storage: {eop, wdata}
    logic [48:0]           mem [DEPTH];
    logic [ADDR_NBITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_NBITS:0]   count, count_nxt;
    logic                  full_q, fullm1_q;
    logic                  push, pop, empty;
    logic [48:0]           head;
    logic                  head_eop;

    // Walk / result registers
    logic [7:0]  hop_idx, pc_q, flags_q;
    logic [15:0] ptr_q;
    logic [23:0] bytes_q;
    logic        err_q;
    logic        match;

    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign head_eop = head[48];

    // full_q tracks count exactly, so using it to drop pushes never loses data.
    assign push = bus.hop_fifo_wr & ~full_q & ~bus.hop_fifo_reset;
    assign pop  = ((state == IDLE) | (state == WALK)) & ~empty & ~bus.hop_fifo_reset;

    // A saturated index (255) is never allowed to select a hop.
    assign match = (hop_idx == pc_q) & (hop_idx != 8'hFF);

    always_comb begin
        count_nxt = count;
        if (push & ~pop)
            count_nxt = count + (ADDR_NBITS+1)'(1);
        else if (pop & ~push)
            count_nxt = count - (ADDR_NBITS+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.hop_fifo_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            fullm1_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_NBITS'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_NBITS'(1);
            count    <= count_nxt;
            full_q   <= (count_nxt == FULL_CNT);
            fullm1_q <= (count_nxt >= FULLM1_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.hop_fifo_eop, bus.hop_fifo_wdata};
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (bus.hop_fifo_reset) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (!empty) state_nxt = head_eop ? OUT : WALK;
                WALK:     if (!empty && (match || head_eop)) state_nxt = OUT;
                OUT:      if (bus.hop_ready) state_nxt = DONE;
                DONE:     state_nxt = WAIT_RST;
                WAIT_RST: state_nxt = WAIT_RST;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs (decoded from the state register only)
    always_comb begin
        bus.hop_valid   = 1'b0;
        bus.parser_done = 1'b0;
        case (state)
            OUT:     bus.hop_valid   = 1'b1;
            DONE:    bus.parser_done = 1'b1;
            default: ;
        endcase
    end

    // Anchor / hop latching
    always_ff @(posedge clk) begin
        if (rst) begin
            hop_idx <= '0;
            pc_q    <= '0;
            flags_q <= '0;
            ptr_q   <= '0;
            bytes_q <= '0;
            err_q   <= 1'b0;
        end else if (pop) begin
            if (state == IDLE) begin
                pc_q    <= head[15:8];
                flags_q <= head[7:0];
                hop_idx <= '0;
                // A lone anchor with eop has no hop to select.
                if (head_eop) begin
                    ptr_q   <= head[47:32];
                    bytes_q <= head[31:8];
                    err_q   <= 1'b1;
                end
            end else if (match) begin
                ptr_q   <= head[47:32];
                bytes_q <= head[31:8];
                err_q   <= 1'b0;
            end else if (head_eop) begin
                ptr_q   <= head[47:32];
                bytes_q <= head[31:8];
                err_q   <= 1'b1;
            end else if (hop_idx != 8'hFF) begin
                hop_idx <= hop_idx + 8'd1;
            end
        end
    end

    assign bus.hop_fifo_full   = full_q;
    assign bus.hop_fifo_fullm1 = fullm1_q;
    assign bus.hop_ptr         = ptr_q;
    assign bus.hop_type        = bytes_q[23:21];
    assign bus.hop_is_ins      = bytes_q[20];
    assign bus.hop_bytes       = bytes_q;
    assign bus.hop_pc          = pc_q;
    assign bus.hop_flags       = flags_q;
    assign bus.hop_err         = err_q;

endmodule
